tagged_stream_fifo: RTL and testbench

- Parametrised successor to the tagged ray-direction FIFO: generic-width, generic-depth synchronous FIFO with valid/ready handshakes on both sides.
- First-word-fall-through (FWFT) output, correct simultaneous push/pop at every occupancy, synchronous flush, occupancy count and watermark flags.
- Sits between ray-generation and traversal stages; the payload is any packed struct, typically TaggedDirection_len.

---
 rtl/tagged_stream_fifo_if.sv | 11 +
 rtl/tagged_stream_fifo.sv | 118 +++++++++++
 tb/tb_tagged_stream_fifo.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tagged_stream_fifo_if.sv
// Valid/ready/data stream bundle used on both sides of tagged_stream_fifo.
interface tagged_stream_fifo_if #(
  parameter int DATA_W = 128
) ();
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/tagged_stream_fifo.sv
// First-word-fall-through stream FIFO with flush, occupancy and watermark flags.
// Optional high-water mark register enabled by defining TAGGED_FIFO_HWM_EN.
module tagged_stream_fifo #(
  parameter int DATA_W    = 128,
  parameter int DEPTH     = 32,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 2,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush,
  tagged_stream_fifo_if.slave     in_bus,
  tagged_stream_fifo_if.master    out_bus,
  output logic [CW-1:0]           count,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic                    overflow,
  output logic [CW-1:0]           hwm
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  // Small DEPTH makes DEPTH-4 negative; clamp so the flag stays meaningful.
  localparam int AF_CLAMP = (AF_THRESH < 0) ? 0 : AF_THRESH;
  localparam logic [CW-1:0] AF_CNT = CW'(AF_CLAMP);
  localparam logic [CW-1:0] AE_CNT = CW'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          overflow_reg;
  logic          in_ready_int;
  logic          out_valid_int;
  logic          push;
  logic          pop;

  assign in_ready_int  = (count_reg != FULL_CNT) && !flush && reset_n;
  assign out_valid_int = (count_reg != '0) && reset_n;
  assign push          = in_bus.valid && in_ready_int;
  assign pop           = out_valid_int && out_bus.ready;

  assign in_bus.ready  = in_ready_int;
  assign out_bus.valid = out_valid_int;
  assign out_bus.data  = mem[rd_ptr_reg];

  assign count         = count_reg;
  assign almost_full   = (count_reg >= AF_CNT);
  assign almost_empty  = (count_reg <= AE_CNT);
  assign overflow      = overflow_reg;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      // Explicit wrap compare keeps non-power-of-two depths correct.
      if (push) begin
        wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= in_bus.valid && !in_ready_int && !flush;
    end
  end

  // Storage has no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= in_bus.data;
    end
  end

`ifdef TAGGED_FIFO_HWM_EN
  logic [CW-1:0] hwm_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hwm_reg <= '0;
    end else if (flush) begin
      hwm_reg <= '0;
    end else if (count_next > hwm_reg) begin
      hwm_reg <= count_next;
    end
  end

  assign hwm = hwm_reg;
`else
  assign hwm = '0;
`endif

endmodule

// File: tb/tb_tagged_stream_fifo.sv
// Directed bench: DEPTH=32 instance for fill/overflow/wrap/flush/reset and a
// DEPTH=5 instance driven from a vector table for non-power-of-two wrap.
module tb_tagged_stream_fifo;

`ifdef TAGGED_FIFO_HWM_EN
  localparam bit HWM_ON = 1'b1;
`else
  localparam bit HWM_ON = 1'b0;
`endif

  logic clk;
  logic reset_n;
  logic flush_a;
  logic flush_b;

  int total;
  int bad;

  tagged_stream_fifo_if #(.DATA_W(32)) a_in  ();
  tagged_stream_fifo_if #(.DATA_W(32)) a_out ();
  tagged_stream_fifo_if #(.DATA_W(8))  b_in  ();
  tagged_stream_fifo_if #(.DATA_W(8))  b_out ();

  logic [5:0] a_count, a_hwm;
  logic       a_af, a_ae, a_ovf;
  logic [2:0] b_count, b_hwm;
  logic       b_af, b_ae, b_ovf;

  tagged_stream_fifo #(.DATA_W(32), .DEPTH(32)) dut_a (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush_a),
    .in_bus       (a_in),
    .out_bus      (a_out),
    .count        (a_count),
    .almost_full  (a_af),
    .almost_empty (a_ae),
    .overflow     (a_ovf),
    .hwm          (a_hwm)
  );

  tagged_stream_fifo #(.DATA_W(8), .DEPTH(5)) dut_b (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush_b),
    .in_bus       (b_in),
    .out_bus      (b_out),
    .count        (b_count),
    .almost_full  (b_af),
    .almost_empty (b_ae),
    .overflow     (b_ovf),
    .hwm          (b_hwm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    int         e_count;
    logic       e_in_ready;
    logic       e_out_valid;
    logic [7:0] e_out_data;
    logic       e_ovf;
  } vec_t;

  vec_t vt [23];
  logic [31:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_n = 1'b0;
    flush_a = 1'b0;
    flush_b = 1'b0;
    a_in.valid = 1'b0; a_in.data = '0; a_out.ready = 1'b0;
    b_in.valid = 1'b0; b_in.data = '0; b_out.ready = 1'b0;

    // Table for the DEPTH=5 instance: inputs, then state after the edge.
    vt[0]  = '{0, 1, 8'h11, 0, 1, 1, 1, 8'h11, 0};
    vt[1]  = '{0, 1, 8'h22, 0, 2, 1, 1, 8'h11, 0};
    vt[2]  = '{0, 1, 8'h33, 0, 3, 1, 1, 8'h11, 0};
    vt[3]  = '{0, 1, 8'h44, 0, 4, 1, 1, 8'h11, 0};
    vt[4]  = '{0, 1, 8'h55, 0, 5, 0, 1, 8'h11, 0};
    vt[5]  = '{0, 1, 8'h66, 1, 4, 1, 1, 8'h22, 1};
    vt[6]  = '{0, 1, 8'h66, 1, 4, 1, 1, 8'h33, 0};
    vt[7]  = '{0, 1, 8'h77, 1, 4, 1, 1, 8'h44, 0};
    vt[8]  = '{0, 1, 8'h88, 1, 4, 1, 1, 8'h55, 0};
    vt[9]  = '{0, 1, 8'h99, 1, 4, 1, 1, 8'h66, 0};
    vt[10] = '{0, 1, 8'haa, 1, 4, 1, 1, 8'h77, 0};
    vt[11] = '{0, 1, 8'hbb, 1, 4, 1, 1, 8'h88, 0};
    vt[12] = '{0, 1, 8'hcc, 1, 4, 1, 1, 8'h99, 0};
    vt[13] = '{0, 1, 8'hdd, 1, 4, 1, 1, 8'haa, 0};
    vt[14] = '{0, 1, 8'hee, 1, 4, 1, 1, 8'hbb, 0};
    vt[15] = '{0, 1, 8'hff, 1, 4, 1, 1, 8'hcc, 0};
    vt[16] = '{0, 1, 8'h01, 1, 4, 1, 1, 8'hdd, 0};
    vt[17] = '{0, 0, 8'h00, 1, 3, 1, 1, 8'hee, 0};
    vt[18] = '{0, 0, 8'h00, 1, 2, 1, 1, 8'hff, 0};
    vt[19] = '{0, 0, 8'h00, 1, 1, 1, 1, 8'h01, 0};
    vt[20] = '{0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0};
    vt[21] = '{1, 1, 8'h5a, 1, 0, 0, 0, 8'h00, 0};
    vt[22] = '{0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0};

    // Reset state
    step();
    step();
    chk("rst_in_ready", 32'(a_in.ready), 32'd0);
    chk("rst_out_valid", 32'(a_out.valid), 32'd0);
    chk("rst_count", 32'(a_count), 32'd0);
    chk("rst_overflow", 32'(a_ovf), 32'd0);
    chk("rst_hwm", 32'(a_hwm), 32'd0);
    reset_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(a_in.ready), 32'd1);
    chk("rel_almost_empty", 32'(a_ae), 32'd1);
    chk("rel_b_in_ready", 32'(b_in.ready), 32'd1);
    $display("reset released: count=%0d in_ready=%0b", a_count, a_in.ready);

    // Fill 32 words with consumer stalled
    for (int i = 1; i <= 32; i++) begin
      a_in.valid = 1'b1;
      a_in.data  = 32'(i);
      step();
      chk("fill_count", 32'(a_count), 32'(i));
      chk("fill_af", 32'(a_af), 32'(i >= 28));
      chk("fill_ae", 32'(a_ae), 32'(i <= 2));
      chk("fill_head", a_out.data, 32'h1);
    end
    a_in.valid = 1'b0;
    chk("full_in_ready", 32'(a_in.ready), 32'd0);
    chk("full_hwm", 32'(a_hwm), HWM_ON ? 32'd32 : 32'd0);
    $display("fill done: count=%0d af=%0b", a_count, a_af);

    // Writes into a full FIFO
    a_in.valid = 1'b1;
    a_in.data  = 32'hdead;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ovf_pulse", 32'(a_ovf), 32'd1);
      chk("ovf_count", 32'(a_count), 32'd32);
    end
    a_in.valid = 1'b0;
    step();
    chk("ovf_clear", 32'(a_ovf), 32'd0);
    chk("ovf_head", a_out.data, 32'h1);
    $display("overflow done: count=%0d head=%0h", a_count, a_out.data);

    // Drain in order
    a_out.ready = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      chk("drain_valid", 32'(a_out.valid), 32'd1);
      chk("drain_data", a_out.data, 32'(i));
      step();
    end
    a_out.ready = 1'b0;
    chk("drain_empty_valid", 32'(a_out.valid), 32'd0);
    chk("drain_empty_count", 32'(a_count), 32'd0);
    $display("drain done: count=%0d out_valid=%0b", a_count, a_out.valid);

    // Simultaneous push/pop at count 5 across pointer wrap
    for (int k = 0; k < 5; k++) begin
      a_in.valid = 1'b1;
      a_in.data  = 32'h100 + 32'(k);
      exp_q.push_back(32'h100 + 32'(k));
      step();
    end
    chk("pp_start_count", 32'(a_count), 32'd5);
    a_out.ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      a_in.data = 32'h200 + 32'(k);
      chk("pp_data", a_out.data, exp_q[0]);
      step();
      void'(exp_q.pop_front());
      exp_q.push_back(32'h200 + 32'(k));
      chk("pp_count", 32'(a_count), 32'd5);
    end
    a_out.ready = 1'b0;
    $display("push/pop done: count=%0d head=%0h", a_count, a_out.data);

    // Flush at count 7 with a write attempt
    for (int k = 0; k < 2; k++) begin
      a_in.data = 32'h300 + 32'(k);
      step();
    end
    chk("pre_flush_count", 32'(a_count), 32'd7);
    flush_a     = 1'b1;
    a_in.valid  = 1'b1;
    a_in.data   = 32'hbeef;
    a_out.ready = 1'b1;
    #1;
    chk("flush_in_ready", 32'(a_in.ready), 32'd0);
    step();
    flush_a     = 1'b0;
    a_in.valid  = 1'b0;
    a_out.ready = 1'b0;
    chk("flush_count", 32'(a_count), 32'd0);
    chk("flush_out_valid", 32'(a_out.valid), 32'd0);
    chk("flush_hwm", 32'(a_hwm), 32'd0);
    chk("flush_ovf", 32'(a_ovf), 32'd0);
    a_in.valid = 1'b1;
    a_in.data  = 32'h55;
    step();
    a_in.valid = 1'b0;
    chk("post_flush_count", 32'(a_count), 32'd1);
    chk("post_flush_head", a_out.data, 32'h55);
    a_out.ready = 1'b1;
    step();
    a_out.ready = 1'b0;
    chk("post_flush_empty", 32'(a_count), 32'd0);
    $display("flush done: count=%0d", a_count);

    // DEPTH=5 vector table
    for (int v = 0; v < 23; v++) begin
      flush_b     = vt[v].flush;
      b_in.valid  = vt[v].in_valid;
      b_in.data   = vt[v].in_data;
      b_out.ready = vt[v].out_ready;
      step();
      chk("b_count", 32'(b_count), 32'(vt[v].e_count));
      chk("b_in_ready", 32'(b_in.ready), 32'(vt[v].e_in_ready));
      chk("b_out_valid", 32'(b_out.valid), 32'(vt[v].e_out_valid));
      chk("b_ovf", 32'(b_ovf), 32'(vt[v].e_ovf));
      chk("b_af", 32'(b_af), 32'(vt[v].e_count >= 1));
      chk("b_ae", 32'(b_ae), 32'(vt[v].e_count <= 2));
      if (vt[v].e_out_valid) begin
        chk("b_out_data", 32'(b_out.data), 32'(vt[v].e_out_data));
      end
      $display("vec %0d: count=%0d out_valid=%0b out_data=%0h ovf=%0b",
               v, b_count, b_out.valid, b_out.data, b_ovf);
    end
    flush_b = 1'b0; b_in.valid = 1'b0; b_out.ready = 1'b0;

    // Asynchronous reset at count 10
    for (int k = 0; k < 10; k++) begin
      a_in.valid = 1'b1;
      a_in.data  = 32'h400 + 32'(k);
      step();
    end
    chk("prerst_count", 32'(a_count), 32'd10);
    chk("prerst_valid", 32'(a_out.valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(a_out.valid), 32'd0);
    chk("arst_in_ready", 32'(a_in.ready), 32'd0);
    chk("arst_count", 32'(a_count), 32'd0);
    chk("arst_hwm", 32'(a_hwm), 32'd0);
    a_in.valid = 1'b0;
    #2;
    reset_n = 1'b1;
    step();
    chk("arel_count", 32'(a_count), 32'd0);
    chk("arel_in_ready", 32'(a_in.ready), 32'd1);
    chk("arel_overflow", 32'(a_ovf), 32'd0);
    chk("arel_out_valid", 32'(a_out.valid), 32'd0);
    $display("async reset done: count=%0d in_ready=%0b", a_count, a_in.ready);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
